compressed_sample_packer: RTL and testbench
===========================================

Name: compressed_sample_packer

Overview:
Sits directly downstream of the compression engine and consumes its {exponent, mantissa} pairs through a valid/ready handshake. Packs 16-bit compressed samples into wide output words, SAMPLES_PER_WORD samples per word, and buffers completed words in a small output FIFO toward the memory/link interface. A flush request closes a partially filled word early, zero-fills its unused slots and tags it as last.

Parameters:
SAMPLES_PER_WORD, 4, samples packed per output word (power of 2, >=2)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock; all logic is rising-edge
reset  input  1  asynchronous, active-low reset (asserted at 0), synchronous deassert handled externally
in_valid_i  input  1  compressed sample valid
in_ready_o  output  1  packer can accept a sample this cycle
mantissa_i  input  12  mantissa from compression stage
exponent_i  input  4  exponent from compression stage
flush_i  input  1  flush request; level, held until flush_ack_o
flush_ack_o  output  1  flush accepted this cycle
out_valid_o  output  1  FIFO head word valid
out_ready_i  input  1  downstream accepts head word
out_data_o  output  16*SAMPLES_PER_WORD  packed word; slot k = bits [16k+15:16k] = {exponent, mantissa}
out_count_o  output  $clog2(SAMPLES_PER_WORD+1)  number of valid slots in head word (1..SAMPLES_PER_WORD)
out_last_o  output  1  head word was closed by a flush

Behaviour:
- Reset (reset=0, async): slot counter=0, accumulator=0, FIFO empty, FSM=FILL; in_ready_o=1 once released, out_valid_o=0, out_data_o=0, out_count_o=0, out_last_o=0, flush_ack_o=0. Reset mid-word or mid-flush discards all partial and buffered data.
- Sample accept: in_valid_i & in_ready_o. Sample written to slot = slot counter; counter increments.
- in_ready_o = (FSM==FILL) & (FIFO not full). Registered-state only; no combinational path from out_ready_i or flush_i.
- Word complete: accepting the sample into slot SAMPLES_PER_WORD-1 pushes {accumulator with new sample, count=SAMPLES_PER_WORD, last=0} into the FIFO in the same edge; counter wraps to 0; accumulator cleared to 0.
- Latency: completing sample at edge N -> out_valid_o=1 after edge N (visible in cycle N+1) if FIFO was empty.
- FIFO: out_valid_o = not empty; out_data_o/out_count_o/out_last_o driven from head entry (0 when empty). Pop on out_valid_o & out_ready_i. Simultaneous push and pop when full is not possible (in_ready_o=0 when full); push and pop in same cycle otherwise both take effect.
- FSM states: FILL, FLUSH.
  - FILL -> FLUSH when flush_i=1.
  - FLUSH: in_ready_o=0. If counter==0: flush_ack_o=1, nothing pushed, -> FILL. If counter>0 and FIFO not full: push {accumulator, count=counter, last=1}, unused slots zero, flush_ack_o=1, counter=0, accumulator=0, -> FILL. If FIFO full: wait, flush_ack_o=0.
  - flush_ack_o is a one-cycle pulse; requester drops flush_i the cycle after ack. flush_i still high after ack re-enters FLUSH (with counter==0, acks next cycle with no push).
- Simultaneous sample accept and flush_i rise in FILL: sample is taken first (included in flushed word); FSM enters FLUSH after that edge.
- Flush exactly when counter wraps to 0 in the same cycle: full word pushed with last=0; flush then acks with no extra word.
- Inputs mantissa_i/exponent_i ignored when not accepted.

Decomposition:
- Package compression_pkg: CE_MANT_W=12, CE_EXP_W=4, CE_SAMPLE_W=16, typedef ce_sample_t packed struct {exponent[3:0], mantissa[11:0]}, enum packer_state_e {PK_FILL, PK_FLUSH}.
- One sub-module: packer_sync_fifo (width = 16*SAMPLES_PER_WORD + count width + 1, depth FIFO_DEPTH, full/empty flags, same clk/async active-low reset).

Test Plan:
- 4 samples {exp=1,man=0x001}..{exp=4,man=0x004}, out_ready_i=1 -> one word 0x4004_3003_2002_1001, count=4, last=0, valid in cycle after 4th accept.
- 2 samples {3,0xABC},{5,0x123} then flush_i -> word 0x0000_0000_5123_3ABC, count=2, last=1; flush_ack_o one pulse; counter back to 0.
- out_ready_i=0, feed 4*FIFO_DEPTH+1 samples -> in_ready_o drops after 16th sample; holds 0; raising out_ready_i drains 4 words in order, then 17th sample accepted.
- flush_i with counter==0 -> flush_ack_o next cycle, no FIFO push, out_valid_o stays 0.
- Sample accept and flush_i in same cycle after 3 prior samples -> full word count=4, last=0; flush ack with no extra word.
- Assert reset=0 mid-word (2 samples held, 2 words buffered) -> out_valid_o=0 immediately, after release first new 4 samples form first output word.

Source files
------------

// File: rtl/compression_pkg.sv
// Shared types for the compression datapath: sample layout and packer FSM states.
package compression_pkg;

  localparam int CE_MANT_W   = 12;
  localparam int CE_EXP_W    = 4;
  localparam int CE_SAMPLE_W = 16;

  typedef struct packed {
    logic [CE_EXP_W-1:0]  exponent;
    logic [CE_MANT_W-1:0] mantissa;
  } ce_sample_t;

  typedef enum logic {
    PK_FILL,
    PK_FLUSH
  } packer_state_e;

endpackage

// File: rtl/packer_sync_fifo.sv
// Single-clock FIFO holding completed packer words; head reads as zero when empty.
module packer_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/compressed_sample_packer.sv
// Packs {exponent, mantissa} samples into wide words and queues them; a flush
// closes a partial word early, zero-filled and tagged last.
module compressed_sample_packer
  import compression_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_WORD = 4,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid_i,
  output logic                                    in_ready_o,
  input  logic [11:0]                             mantissa_i,
  input  logic [3:0]                              exponent_i,
  input  logic                                    flush_i,
  output logic                                    flush_ack_o,
  output logic                                    out_valid_o,
  input  logic                                    out_ready_i,
  output logic [16*SAMPLES_PER_WORD-1:0]          out_data_o,
  output logic [$clog2(SAMPLES_PER_WORD+1)-1:0]   out_count_o,
  output logic                                    out_last_o
);

  localparam int unsigned WORD_W = CE_SAMPLE_W * SAMPLES_PER_WORD;
  localparam int unsigned CNT_W  = $clog2(SAMPLES_PER_WORD + 1);
  localparam int unsigned SLOT_W = $clog2(SAMPLES_PER_WORD);
  localparam int unsigned ENT_W  = WORD_W + CNT_W + 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SAMPLES_PER_WORD - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(SAMPLES_PER_WORD);

  packer_state_e     state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  ce_sample_t        sample;
  logic              accept;
  logic              push;
  logic [ENT_W-1:0]  push_entry;
  logic [ENT_W-1:0]  head;
  logic              full;
  logic              empty;

  assign sample.exponent = exponent_i;
  assign sample.mantissa = mantissa_i;

  assign in_ready_o  = (state_q == PK_FILL) & ~full;
  assign accept      = in_valid_i & in_ready_o;
  assign flush_ack_o = (state_q == PK_FLUSH) & ((slot_q == '0) | ~full);

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    acc_d      = acc_q;
    push       = 1'b0;
    push_entry = '0;
    unique case (state_q)
      PK_FILL: begin
        if (accept) begin
          acc_d[int'(slot_q)*CE_SAMPLE_W +: CE_SAMPLE_W] = sample;
          if (slot_q == LAST_SLOT) begin
            push       = 1'b1;
            push_entry = {1'b0, FULL_CNT, acc_d};
            acc_d      = '0;
            slot_d     = '0;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
        // A sample arriving with the flush request lands in the flushed word.
        if (flush_i) begin
          state_d = PK_FLUSH;
        end
      end
      PK_FLUSH: begin
        if (flush_ack_o) begin
          // Unused slots are already zero because the accumulator clears on every close.
          if (slot_q != '0) begin
            push       = 1'b1;
            push_entry = {1'b1, CNT_W'(slot_q), acc_q};
          end
          slot_d  = '0;
          acc_d   = '0;
          state_d = PK_FILL;
        end
      end
      default: state_d = PK_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PK_FILL;
      slot_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      acc_q   <= acc_d;
    end
  end

  packer_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (out_valid_o & out_ready_i),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign out_valid_o = ~empty;
  assign {out_last_o, out_count_o, out_data_o} = head;

endmodule

// File: tb/tb_compressed_sample_packer.sv
// Directed bench for compressed_sample_packer (4 samples/word, 4-entry FIFO).
module tb_compressed_sample_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [11:0] mantissa_i;
  logic [3:0]  exponent_i;
  logic        flush_i;
  logic        flush_ack_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] out_data_o;
  logic [2:0]  out_count_o;
  logic        out_last_o;

  int total = 0;
  int bad   = 0;

  compressed_sample_packer #(
    .SAMPLES_PER_WORD (4),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .mantissa_i  (mantissa_i),
    .exponent_i  (exponent_i),
    .flush_i     (flush_i),
    .flush_ack_o (flush_ack_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_count_o (out_count_o),
    .out_last_o  (out_last_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] samp(input int k);
    logic [15:0] r;
    r[15:12] = 4'(k & 15);
    r[11:0]  = 12'h100 + 12'(k);
    return r;
  endfunction

  function automatic logic [63:0] word_of(input int w);
    logic [63:0] r;
    for (int s = 0; s < 4; s++) r[16*s +: 16] = samp(4*w + s);
    return r;
  endfunction

  task automatic drive(input logic [3:0] e, input logic [11:0] m);
    in_valid_i = 1'b1;
    exponent_i = e;
    mantissa_i = m;
  endtask

  initial begin
    reset = 1'b0; in_valid_i = 1'b0; mantissa_i = '0; exponent_i = '0;
    flush_i = 1'b0; out_ready_i = 1'b0;
    step(); step();
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_data", out_data_o, 64'd0);
    chk("rst_out_count", 64'(out_count_o), 64'd0);
    chk("rst_out_last", 64'(out_last_o), 64'd0);
    chk("rst_flush_ack", 64'(flush_ack_o), 64'd0);
    reset = 1'b1;
    step();
    chk("rel_in_ready", 64'(in_ready_o), 64'd1);

    // Full word of four samples
    out_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(4'(i), 12'(i));
      chk("w1_in_ready", 64'(in_ready_o), 64'd1);
      chk("w1_not_yet_valid", 64'(out_valid_o), 64'd0);
      step();
    end
    in_valid_i = 1'b0;
    chk("w1_valid", 64'(out_valid_o), 64'd1);
    chk("w1_data", out_data_o, 64'h4004_3003_2002_1001);
    chk("w1_count", 64'(out_count_o), 64'd4);
    chk("w1_last", 64'(out_last_o), 64'd0);
    step();
    chk("w1_popped", 64'(out_valid_o), 64'd0);

    // Partial word closed by flush
    drive(4'd3, 12'hABC); step();
    drive(4'd5, 12'h123); step();
    in_valid_i = 1'b0;
    flush_i = 1'b1;
    chk("fl_no_ack_fill", 64'(flush_ack_o), 64'd0);
    step();
    chk("fl_ack", 64'(flush_ack_o), 64'd1);
    chk("fl_in_ready_low", 64'(in_ready_o), 64'd0);
    step();
    flush_i = 1'b0;
    chk("fl_ack_pulse", 64'(flush_ack_o), 64'd0);
    chk("fl_valid", 64'(out_valid_o), 64'd1);
    chk("fl_data", out_data_o, 64'h0000_0000_5123_3ABC);
    chk("fl_count", 64'(out_count_o), 64'd2);
    chk("fl_last", 64'(out_last_o), 64'd1);
    chk("fl_in_ready_back", 64'(in_ready_o), 64'd1);
    step();
    chk("fl_popped", 64'(out_valid_o), 64'd0);

    // Backpressure: fill the FIFO, 17th sample must wait
    out_ready_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive(samp(k)[15:12], samp(k)[11:0]);
      chk("bp_in_ready", 64'(in_ready_o), 64'd1);
      step();
    end
    drive(samp(16)[15:12], samp(16)[11:0]);
    chk("bp_full_stall", 64'(in_ready_o), 64'd0);
    step();
    chk("bp_full_hold", 64'(in_ready_o), 64'd0);
    out_ready_i = 1'b1;
    chk("bp_w0", out_data_o, word_of(0));
    step();
    chk("bp_ready_again", 64'(in_ready_o), 64'd1);
    chk("bp_w1", out_data_o, word_of(1));
    step();
    in_valid_i = 1'b0;
    chk("bp_w2", out_data_o, word_of(2));
    step();
    chk("bp_w3", out_data_o, word_of(3));
    chk("bp_w3_count", 64'(out_count_o), 64'd4);
    step();
    chk("bp_drained", 64'(out_valid_o), 64'd0);
    flush_i = 1'b1;
    step();
    chk("bp_fl_ack", 64'(flush_ack_o), 64'd1);
    step();
    flush_i = 1'b0;
    chk("bp_s16_data", out_data_o, {48'd0, samp(16)});
    chk("bp_s16_count", 64'(out_count_o), 64'd1);
    chk("bp_s16_last", 64'(out_last_o), 64'd1);
    step();
    chk("bp_s16_popped", 64'(out_valid_o), 64'd0);

    // Flush with empty accumulator
    flush_i = 1'b1;
    step();
    chk("ef_ack", 64'(flush_ack_o), 64'd1);
    chk("ef_no_push_a", 64'(out_valid_o), 64'd0);
    step();
    flush_i = 1'b0;
    chk("ef_ack_drop", 64'(flush_ack_o), 64'd0);
    chk("ef_no_push_b", 64'(out_valid_o), 64'd0);

    // Fourth sample and flush request in the same cycle
    drive(4'd1, 12'h111); step();
    drive(4'd2, 12'h222); step();
    drive(4'd3, 12'h333); step();
    drive(4'd4, 12'h444);
    flush_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    chk("sf_data", out_data_o, 64'h4444_3333_2222_1111);
    chk("sf_count", 64'(out_count_o), 64'd4);
    chk("sf_last", 64'(out_last_o), 64'd0);
    chk("sf_ack", 64'(flush_ack_o), 64'd1);
    step();
    flush_i = 1'b0;
    chk("sf_no_extra", 64'(out_valid_o), 64'd0);
    chk("sf_ack_drop", 64'(flush_ack_o), 64'd0);

    // Reset mid-word with buffered data
    out_ready_i = 1'b0;
    for (int k = 20; k < 30; k++) begin
      drive(samp(k)[15:12], samp(k)[11:0]);
      step();
    end
    in_valid_i = 1'b0;
    chk("mr_buffered", 64'(out_valid_o), 64'd1);
    reset = 1'b0;
    #1;
    chk("mr_valid_drop", 64'(out_valid_o), 64'd0);
    chk("mr_data_zero", out_data_o, 64'd0);
    step();
    reset = 1'b1;
    step();
    chk("mr_in_ready", 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b1;
    for (int k = 40; k < 44; k++) begin
      drive(samp(k)[15:12], samp(k)[11:0]);
      step();
    end
    in_valid_i = 1'b0;
    chk("mr_first_word", out_data_o, word_of(10));
    chk("mr_first_count", 64'(out_count_o), 64'd4);
    step();
    chk("mr_only_word", 64'(out_valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
